sprite_anim_ctrl: RTL
=====================

# sprite_anim_ctrl

Sequences the sprite animation for the player and boss in the VGA game. Generates the 4-bit `player_state`/`boss_state` frame indices consumed by the sprite address generator, and latches sprite positions once per video frame so a sprite never tears mid-scan. Sits between game logic (movement/combat requests) and the sprite drawing datapath. Steps animations on a divided vertical-sync tick.

## Interface
- `FRAME_DIV`, 6: vsync ticks per animation step (2..15).
- `WALK_LEN`, 4: walk-cycle frames, indices 1..WALK_LEN.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `vsync_tick` in 1: one-cycle pulse at the start of vertical blanking.
- `state` in 4: game state (STAGE1=2, STAGE2=4, STAGE3=6).
- `player_move`, `boss_move` in 1: level, sprite is moving.
- `player_atk`, `boss_atk` in 1: one-cycle attack request.
- `player_hit`, `boss_hit` in 1: one-cycle hit event.
- `player_x_nxt`, `player_y_nxt`, `boss_x_nxt`, `boss_y_nxt` in 9: game-logic positions (320x240 space).
- `player_x`, `player_y`, `boss_x`, `boss_y` out 9: frame-stable positions.
- `player_state`, `boss_state` out 4: animation frame index.
- `player_busy`, `boss_busy` out 1: one-shot (attack/hit) animation in progress.

## Operation
- Frame index map: IDLE=0, WALK=1..WALK_LEN, ATTACK=5,6,7, HIT=8,9. Indices 10..15 are never emitted.
- Per-sprite FSM states:
  - IDLE
  - WALK: cycles 1..WALK_LEN, wraps to 1.
  - ATTACK: one-shot, 5→6→7.
  - HIT: one-shot, 8→9.
- Step: a shared divider counts `vsync_tick` from 0 to FRAME_DIV-1. A step is the tick on which the count equals FRAME_DIV-1; the count then wraps to 0.
- Requests:
  - `*_atk` and `*_hit` are captured into sticky pending bits on any cycle.
  - Pending bits are consumed at the next step.
  - An `*_atk` arriving while busy with ATTACK or HIT is dropped, and its pending bit is not set.
- At each step, evaluate in priority order:
  1. Hit pending: enter HIT at index 8. This preempts ATTACK and WALK.
  2. Attack pending and not busy: enter ATTACK at index 5.
  3. One-shot active: advance. At its last index (7 or 9), go to WALK if `*_move`, else IDLE.
  4. `*_move` high: WALK. Enter at index 1 from IDLE, otherwise advance with wrap.
  5. Otherwise: IDLE.
- `*_busy` = 1 while in ATTACK or HIT, including the last index.
- Boss FSM runs only when `state`==STAGE3. In any other state the boss is held in IDLE, `boss_state`=0, and its pending bits are cleared.
- Player FSM runs in STAGE1..STAGE3. In other states it is held in IDLE.
- Stage change: any change of `state` from the prior cycle clears both FSMs, the pending bits and the divider, all in that cycle.
- Positions: all four `*_nxt` values are copied to the outputs on every `vsync_tick`, not only on steps. Outputs are held between ticks.

## Timing
- Reset value of every output is 0; FSMs, divider and pending bits are also 0.
- All outputs are registered. They update on the clock edge that samples the relevant `vsync_tick`, so they are visible the following cycle (latency 1).
- A request on the same cycle as a step tick is taken at that step.
- Hit and attack on the same cycle: hit wins, and the attack is dropped.
- Stage change and step tick on the same cycle: the stage clear wins, and the positions still load.
- Reset mid-animation: the block returns to IDLE on the next edge with `rst_n`=0.

## Configuration
- `ANIM_HIT_EN` defined: HIT state, hit pending bits and indices 8..9 are present.
- `ANIM_HIT_EN` undefined:
  - `*_hit` inputs are ignored.
  - The FSM has no HIT state and indices never exceed 7.
  - `*_busy` reflects ATTACK only.

## Structure
- Package `anim_pkg` holds:
  - stage constants STAGE1/2/3;
  - the animation-state enum;
  - frame base constants IDLE_F=0, WALK_F=1, ATK_F=5, HIT_F=8, plus ATK_LEN=3 and HIT_LEN=2.
- Sub-module `anim_fsm` holds one sprite's FSM and pending bits. It is instantiated twice, with an enable input for the stage gating.
- The top level holds the shared divider, stage-change detect and position registers.

## Test plan
- Reset, then FRAME_DIV=6 with `player_move`=1 in STAGE1: `player_state` goes 1,2,3,4,1 at ticks 6,12,18,24,30. Every output is 0 before the first step.
- `player_atk` pulsed mid-walk: at the next step `player_state`=5, then 6, 7, then walk resumes. `player_busy` is 1 for exactly 3 steps. A second `player_atk` during this window is ignored.
- `player_hit` during ATTACK index 6: the next step gives 8, then 9, then IDLE (move=0). With `ANIM_HIT_EN` undefined, the attack completes 7 and no 8/9 appears.
- `state` switches STAGE1 to STAGE3 during walk frame 3: both FSMs go to 0 and the divider restarts. In STAGE3, `boss_move`=1 gives `boss_state`=1 after 6 ticks. In STAGE2, `boss_atk` leaves `boss_state`=0.
- `player_x_nxt` changes 100→101 between ticks: `player_x` stays 100 until the cycle after the next `vsync_tick`, then reads 101.
- `player_hit` and `player_atk` on the same cycle as a step tick: `player_state`=8 the next cycle, and the attack never occurs.

Source files
------------

// File: rtl/sprite_anim_ctrl_pkg.sv
// anim_pkg: shared constants and types for the sprite animation controller.
// Optional feature macro: ANIM_HIT_EN (adds the HIT one-shot, indices 8..9).
package anim_pkg;
  localparam logic [3:0] STAGE1 = 4'd2;
  localparam logic [3:0] STAGE2 = 4'd4;
  localparam logic [3:0] STAGE3 = 4'd6;

  localparam logic [3:0] IDLE_F = 4'd0;
  localparam logic [3:0] WALK_F = 4'd1;
  localparam logic [3:0] ATK_F  = 4'd5;
  localparam logic [3:0] HIT_F  = 4'd8;
  localparam int         ATK_LEN = 3;
  localparam int         HIT_LEN = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
`ifdef ANIM_HIT_EN
    ST_HIT  = 2'd3,
`endif
    ST_ATK  = 2'd2
  } anim_st_e;

  function automatic logic is_stage(input logic [3:0] s);
    return (s == STAGE1) || (s == STAGE2) || (s == STAGE3);
  endfunction
endpackage

// File: rtl/sprite_anim_ctrl_if.sv
// Game-logic <-> animation controller bus. master = game side, slave = controller.
interface sprite_anim_ctrl_if;
  logic       vsync_tick;
  logic [3:0] state;
  logic       player_move, boss_move;
  logic       player_atk, boss_atk;
  logic       player_hit, boss_hit;
  logic [8:0] player_x_nxt, player_y_nxt, boss_x_nxt, boss_y_nxt;
  logic [8:0] player_x, player_y, boss_x, boss_y;
  logic [3:0] player_state, boss_state;
  logic       player_busy, boss_busy;

  modport master (
    output vsync_tick, state, player_move, boss_move, player_atk, boss_atk,
           player_hit, boss_hit, player_x_nxt, player_y_nxt, boss_x_nxt, boss_y_nxt,
    input  player_x, player_y, boss_x, boss_y, player_state, boss_state,
           player_busy, boss_busy
  );

  modport slave (
    input  vsync_tick, state, player_move, boss_move, player_atk, boss_atk,
           player_hit, boss_hit, player_x_nxt, player_y_nxt, boss_x_nxt, boss_y_nxt,
    output player_x, player_y, boss_x, boss_y, player_state, boss_state,
           player_busy, boss_busy
  );
endinterface

// File: rtl/sprite_anim_ctrl_fsm.sv
// anim_fsm: one sprite's animation FSM plus its sticky request bits.
// ANIM_HIT_EN adds the HIT one-shot; without it the hit input is ignored.
module anim_fsm
  import anim_pkg::*;
#(
  parameter int WALK_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,     // stage gating: low holds IDLE and drops requests
  input  logic       i_clr,    // stage change: flush everything this cycle
  input  logic       i_step,
  input  logic       i_move,
  input  logic       i_atk,
  input  logic       i_hit,
  output logic [3:0] o_frame,
  output logic       o_busy
);
  localparam logic [3:0] ATK_LAST  = ATK_F + 4'(ATK_LEN - 1);
  localparam logic [3:0] HIT_LAST  = HIT_F + 4'(HIT_LEN - 1);
  localparam logic [3:0] WALK_LAST = 4'(WALK_LEN);

  anim_st_e   r_st;
  logic [3:0] r_frame;
  logic       r_atk_p;
  logic       w_busy, w_last, w_hit, w_atk, w_hit_p, w_atk_p;

`ifdef ANIM_HIT_EN
  logic       r_hit_p;
  assign w_hit   = i_hit;
  assign w_hit_p = r_hit_p | w_hit;
`else
  // hit events have no effect in this build
  assign w_hit   = i_hit & 1'b0;
  assign w_hit_p = w_hit;
`endif

  // busy = a one-shot (ATTACK, or HIT when present) owns the sprite
  always_comb begin
    w_busy = (r_st == ST_ATK);
`ifdef ANIM_HIT_EN
    w_busy = w_busy | (r_st == ST_HIT);
`endif
  end

  assign w_last  = (r_frame == ATK_LAST) || (r_frame == HIT_LAST);
  // attacks are dropped while busy and lose to a same-cycle hit
  assign w_atk   = i_atk & ~w_busy & ~w_hit;
  assign w_atk_p = r_atk_p | w_atk;

  // animation sequencing: requests accumulate between steps, resolved by priority at a step
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr || !i_en) begin
      r_st    <= ST_IDLE;
      r_frame <= IDLE_F;
      r_atk_p <= 1'b0;
`ifdef ANIM_HIT_EN
      r_hit_p <= 1'b0;
`endif
    end else if (i_step) begin
      r_atk_p <= 1'b0;
`ifdef ANIM_HIT_EN
      r_hit_p <= 1'b0;
      if (w_hit_p) begin
        r_st    <= ST_HIT;
        r_frame <= HIT_F;
      end else
`endif
      if (w_atk_p && !w_busy) begin
        r_st    <= ST_ATK;
        r_frame <= ATK_F;
      end else if (w_busy) begin
        if (w_last) begin
          r_st    <= i_move ? ST_WALK : ST_IDLE;
          r_frame <= i_move ? WALK_F : IDLE_F;
        end else begin
          r_frame <= r_frame + 4'd1;
        end
      end else if (i_move) begin
        r_st    <= ST_WALK;
        r_frame <= (r_st == ST_WALK && r_frame != WALK_LAST) ? r_frame + 4'd1 : WALK_F;
      end else begin
        r_st    <= ST_IDLE;
        r_frame <= IDLE_F;
      end
    end else begin
      r_atk_p <= w_atk_p;
`ifdef ANIM_HIT_EN
      r_hit_p <= w_hit_p;
`endif
    end
  end

  assign o_frame = r_frame;
  assign o_busy  = w_busy;
endmodule

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: vsync step divider, stage-change flush, frame-stable
// position latches and the player/boss animation FSMs.
// Optional feature macro: ANIM_HIT_EN.
module sprite_anim_ctrl
  import anim_pkg::*;
#(
  parameter int FRAME_DIV = 6,
  parameter int WALK_LEN  = 4
) (
  input logic               clk,
  input logic               rst_n,
  sprite_anim_ctrl_if.slave bus
);
  logic [3:0] r_div, r_state_q;
  logic [8:0] r_player_x, r_player_y, r_boss_x, r_boss_y;
  logic       w_stage_chg, w_step, w_en_p, w_en_b;

  assign w_stage_chg = (bus.state != r_state_q);
  // a stage change swallows a coinciding step
  assign w_step      = bus.vsync_tick && !w_stage_chg && (r_div == 4'(FRAME_DIV - 1));
  assign w_en_p      = is_stage(bus.state);
  assign w_en_b      = (bus.state == STAGE3);

  // vsync divider and previous-stage tracker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div     <= 4'd0;
      r_state_q <= 4'd0;
    end else begin
      r_state_q <= bus.state;
      if (w_stage_chg)     r_div <= 4'd0;
      else if (w_step)     r_div <= 4'd0;
      else if (bus.vsync_tick) r_div <= r_div + 4'd1;
    end
  end

  // positions sampled once per video frame so sprites never tear mid-scan
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_player_x <= '0;
      r_player_y <= '0;
      r_boss_x   <= '0;
      r_boss_y   <= '0;
    end else if (bus.vsync_tick) begin
      r_player_x <= bus.player_x_nxt;
      r_player_y <= bus.player_y_nxt;
      r_boss_x   <= bus.boss_x_nxt;
      r_boss_y   <= bus.boss_y_nxt;
    end
  end

  anim_fsm #(.WALK_LEN(WALK_LEN)) u_player (
    .clk(clk), .rst_n(rst_n), .i_en(w_en_p), .i_clr(w_stage_chg), .i_step(w_step),
    .i_move(bus.player_move), .i_atk(bus.player_atk), .i_hit(bus.player_hit),
    .o_frame(bus.player_state), .o_busy(bus.player_busy)
  );

  anim_fsm #(.WALK_LEN(WALK_LEN)) u_boss (
    .clk(clk), .rst_n(rst_n), .i_en(w_en_b), .i_clr(w_stage_chg), .i_step(w_step),
    .i_move(bus.boss_move), .i_atk(bus.boss_atk), .i_hit(bus.boss_hit),
    .o_frame(bus.boss_state), .o_busy(bus.boss_busy)
  );

  assign bus.player_x = r_player_x;
  assign bus.player_y = r_player_y;
  assign bus.boss_x   = r_boss_x;
  assign bus.boss_y   = r_boss_y;
endmodule
